// File: rtl/mux_pkg.sv
// Shared types and helpers for the stream multiplexer.
// Holds the arbitration mode encoding and the select-width function.
package mux_pkg;

    typedef enum logic {
        MODE_RR    = 1'b0,
        MODE_FIXED = 1'b1
    } mode_e;

    function automatic int sel_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: first requester at or above ptr, wrapping.
// Purely combinational; grant is one-hot or zero.
module rr_arbiter #(
    parameter int N  = 8,
    parameter int PW = 3
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant
);

    logic          found;
    logic [PW:0]   idx;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            idx = {1'b0, ptr} + (PW+1)'(k);
            if (idx >= (PW+1)'(N))
                idx = idx - (PW+1)'(N);
            if (!found && req[idx[PW-1:0]]) begin
                grant[idx[PW-1:0]] = 1'b1;
                found              = 1'b1;
            end
        end
    end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream mux with round-robin or fixed select.
// One registered output slot; accepts a new beat whenever it drains.
module stream_mux_rr
    import mux_pkg::*;
#(
    parameter  int N_CH  = 8,
    parameter  int W     = 8,
    localparam int SEL_W = sel_width(N_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_CH*W-1:0] in_data,
    input  logic [N_CH-1:0]   in_valid,
    output logic [N_CH-1:0]   in_ready,
    input  logic              sel_mode,
    input  logic [SEL_W-1:0]  sel,
    output logic [W-1:0]      out_data,
    output logic              out_valid,
    output logic [SEL_W-1:0]  out_ch,
    input  logic              out_ready
);

    mode_e             mode;
    logic              load_en;
    logic              xfer;
    logic [SEL_W-1:0]  rr_ptr;
    logic [N_CH-1:0]   rr_grant;
    logic [N_CH-1:0]   fx_grant;
    logic [N_CH-1:0]   grant;
    logic [SEL_W-1:0]  gidx;
    logic [W-1:0]      gdata;

    assign mode    = mode_e'(sel_mode);
    assign load_en = !out_valid || out_ready;

    rr_arbiter #(
        .N  (N_CH),
        .PW (SEL_W)
    ) u_arb (
        .req   (in_valid),
        .ptr   (rr_ptr),
        .grant (rr_grant)
    );

    // Out-of-range select (non-power-of-two N_CH) yields no grant.
    always_comb begin
        fx_grant = '0;
        if (32'(sel) < N_CH)
            fx_grant[sel] = in_valid[sel];
    end

    assign grant    = (mode == MODE_FIXED) ? fx_grant : rr_grant;
    assign in_ready = (rst || !load_en) ? '0 : grant;
    assign xfer     = |in_ready;

    always_comb begin
        gidx  = '0;
        gdata = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (grant[i]) begin
                gidx  = SEL_W'(i);
                gdata = in_data[i*W +: W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            rr_ptr    <= '0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= gdata;
            out_ch    <= gidx;
            if (mode == MODE_RR)
                rr_ptr <= (gidx == SEL_W'(N_CH-1)) ?
                          '0 : gidx + SEL_W'(1);
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Bench for stream_mux_rr: reference model on every cycle plus
// directed literal expectations for the N_CH=8 and N_CH=5 builds.
module tb_stream_mux_rr;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] in_data;
    logic [7:0]  in_valid;
    logic [7:0]  in_ready;
    logic        sel_mode;
    logic [2:0]  sel;
    logic [7:0]  out_data;
    logic        out_valid;
    logic [2:0]  out_ch;
    logic        out_ready;

    logic [39:0] in_data5;
    logic [4:0]  in_valid5;
    logic [4:0]  in_ready5;
    logic        sel_mode5;
    logic [2:0]  sel5;
    logic [7:0]  out_data5;
    logic        out_valid5;
    logic [2:0]  out_ch5;
    logic        out_ready5;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    bit mv;
    int md, mc, mp;

    always #5 clk = ~clk;

    stream_mux_rr #(.N_CH(8), .W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sel_mode  (sel_mode),
        .sel       (sel),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ch    (out_ch),
        .out_ready (out_ready)
    );

    stream_mux_rr #(.N_CH(5), .W(8)) dut5 (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data5),
        .in_valid  (in_valid5),
        .in_ready  (in_ready5),
        .sel_mode  (sel_mode5),
        .sel       (sel5),
        .out_data  (out_data5),
        .out_valid (out_valid5),
        .out_ch    (out_ch5),
        .out_ready (out_ready5)
    );

    task automatic chk(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Channel the spec rules would grant now, or -1.
    function automatic int pick();
        if (sel_mode)
            return in_valid[sel] ? int'(sel) : -1;
        for (int k = 0; k < 8; k++) begin
            int c;
            c = (mp + k) % 8;
            if (in_valid[c])
                return c;
        end
        return -1;
    endfunction

    function automatic logic [7:0] model_ready();
        logic [7:0] r;
        int p;
        r = '0;
        if (!rst && (!mv || out_ready)) begin
            p = pick();
            if (p >= 0)
                r[p] = 1'b1;
        end
        return r;
    endfunction

    always @(posedge clk) begin
        int p;
        if (rst) begin
            mv = 0; md = 0; mc = 0; mp = 0;
        end else begin
            p = pick();
            if ((!mv || out_ready) && p >= 0) begin
                mv = 1;
                md = int'(in_data[p*8 +: 8]);
                mc = p;
                if (!sel_mode)
                    mp = (p + 1) % 8;
            end else if (out_ready) begin
                mv = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_out_valid", 64'(out_valid), 64'(mv));
            chk("m_out_data", 64'(out_data), 64'(md));
            chk("m_out_ch", 64'(out_ch), 64'(mc));
            chk("m_in_ready", 64'(in_ready), 64'(model_ready()));
        end
    end

    task automatic nxt();
        @(posedge clk);
        #2;
    endtask

    task automatic expect_out(input string name,
                              input int ch, input int data);
        chk({name, "_valid"}, 64'(out_valid), 64'd1);
        chk({name, "_ch"}, 64'(out_ch), 64'(ch));
        chk({name, "_data"}, 64'(out_data), 64'(data));
    endtask

    initial begin
        rst        = 1'b1;
        in_valid   = 8'hFF;
        sel_mode   = 1'b0;
        sel        = 3'd0;
        out_ready  = 1'b1;
        for (int i = 0; i < 8; i++)
            in_data[i*8 +: 8] = 8'h10 + 8'(i);
        in_valid5  = 5'h1F;
        sel_mode5  = 1'b1;
        sel5       = 3'd6;
        out_ready5 = 1'b1;
        for (int i = 0; i < 5; i++)
            in_data5[i*8 +: 8] = 8'h50 + 8'(i);

        @(posedge clk);
        #1 chk_en = 1'b1;
        for (int i = 0; i < 2; i++) begin
            nxt();
            chk("rst_in_ready", 64'(in_ready), 64'd0);
            chk("rst_out_valid", 64'(out_valid), 64'd0);
            chk("rst_out_data", 64'(out_data), 64'd0);
            chk("rst_out_ch", 64'(out_ch), 64'd0);
        end

        // Round robin over all eight channels
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            nxt();
            expect_out("rr_all", i % 8, 'h10 + i % 8);
        end

        // Only channels 2 and 6; pointer wraps through 7 -> 0
        in_valid = 8'b0100_0100;
        for (int i = 0; i < 4; i++) begin
            nxt();
            expect_out("rr_2_6", (i % 2) ? 6 : 2,
                       (i % 2) ? 'h16 : 'h12);
        end

        // Fixed select of channel 5
        sel_mode = 1'b1;
        sel = 3'd5;
        in_data[47:40] = 8'hA5;
        in_valid = 8'hFF;
        #1 chk("fx_ready_now", 64'(in_ready), 64'h20);
        for (int i = 0; i < 4; i++) begin
            nxt();
            expect_out("fixed5", 5, 'hA5);
            chk("fixed5_ready", 64'(in_ready), 64'h20);
        end

        // Back to RR: pointer still 7 from before fixed mode
        sel_mode = 1'b0;
        nxt();
        expect_out("rr_resume7", 7, 'h17);
        nxt();
        expect_out("rr_resume0", 0, 'h10);

        // Backpressure holds output and blocks inputs
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            nxt();
            expect_out("bp_hold", 0, 'h10);
            chk("bp_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            nxt();
            expect_out("bp_release", i, 'h10 + i);
        end

        // Drain: valid drops, data and channel hold
        in_valid = 8'h00;
        nxt();
        chk("drain_valid", 64'(out_valid), 64'd0);
        chk("drain_ch", 64'(out_ch), 64'd3);
        chk("drain_data", 64'(out_data), 64'h13);

        // Reset while holding a word
        in_valid = 8'hFF;
        nxt();
        expect_out("pre_rst", 4, 'h14);
        rst = 1'b1;
        #1 chk("mid_rst_ready", 64'(in_ready), 64'd0);
        nxt();
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_data", 64'(out_data), 64'd0);
        rst = 1'b0;
        nxt();
        expect_out("post_rst", 0, 'h10);

        // N_CH=5 with out-of-range select never grants
        for (int i = 0; i < 3; i++) begin
            nxt();
            chk("n5_sel6_valid", 64'(out_valid5), 64'd0);
            chk("n5_sel6_ready", 64'(in_ready5), 64'd0);
        end
        sel5 = 3'd4;
        #1 chk("n5_sel4_ready", 64'(in_ready5), 64'h10);
        nxt();
        chk("n5_sel4_valid", 64'(out_valid5), 64'd1);
        chk("n5_sel4_ch", 64'(out_ch5), 64'd4);
        chk("n5_sel4_data", 64'(out_data5), 64'h54);

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
